key_input_bank: RTL and testbench



---
 rtl/key_input_pkg.sv | 16 +
 rtl/key_channel.sv | 126 ++++++++++++
 rtl/key_input_bank.sv | 70 +++++++
 tb/tb_key_input_bank.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_input_pkg.sv
// Shared definitions for the key input bank.
//   MODE_*   : per-channel output mode encodings
//   get_mode : pulls the 2-bit mode of channel k out of a packed mode vector
package key_input_pkg;

  localparam logic [1:0] MODE_LEVEL  = 2'b00;
  localparam logic [1:0] MODE_RISE   = 2'b01;
  localparam logic [1:0] MODE_FALL   = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  // Channel k occupies bits [2k+1:2k]; callers zero-extend their vector to 64 bits.
  function automatic logic [1:0] get_mode(input logic [63:0] modes, input int k);
    return modes[2*k +: 2];
  endfunction

endpackage

// File: rtl/key_channel.sv
// One debounced key channel: 2-FF synchroniser, debounce counter, edge detect,
// mode output mux, toggle state and long-press detector.
// Ports:
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_key           : raw asynchronous pin level
//   i_toggle_clr    : synchronous clear of the toggle state (wins over a rise)
//   o_key           : output formed according to MODE
//   o_level         : debounced, polarity-normalised pressed level
//   o_long_press    : one-cycle pulse when the hold count reaches LONG_MAX
//   o_edge_next     : rise|fall that will be registered on the next edge
module key_channel
  import key_input_pkg::*;
#(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned CNT_MAX    = 32'h000F_FFFF,
  parameter int unsigned LONG_W     = 28,
  parameter int unsigned LONG_MAX   = 100_000_000,
  parameter logic        ACTIVE_LOW = 1'b0,
  parameter logic [1:0]  MODE       = MODE_LEVEL
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  input  logic i_toggle_clr,
  output logic o_key,
  output logic o_level,
  output logic o_long_press,
  output logic o_edge_next
);

  localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(CNT_MAX);
  localparam logic [LONG_W-1:0] HOLD_TOP = LONG_W'(LONG_MAX);
  localparam logic [LONG_W-1:0] HOLD_PRE = LONG_W'(LONG_MAX - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              toggle_q, toggle_d;
  logic [LONG_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;
  logic              pressed_now;
  logic              pressed_next;

  always_comb begin
    sync1_d  = i_key;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;

    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_TOP) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Edges are computed from the upcoming stable value so the pulses land on
    // the same edge that updates the debounced level.
    pressed_now  = stable_q ^ ACTIVE_LOW;
    pressed_next = stable_d ^ ACTIVE_LOW;
    rise_d       = pressed_next & ~pressed_now;
    fall_d       = ~pressed_next & pressed_now;

    toggle_d = toggle_q;
    if (i_toggle_clr) begin
      toggle_d = 1'b0;
    end else if (rise_d) begin
      toggle_d = ~toggle_q;
    end

    // Saturating hold counter; the pulse fires only on the step into HOLD_TOP.
    hold_d = '0;
    long_d = 1'b0;
    if (pressed_now) begin
      hold_d = hold_q;
      if (hold_q != HOLD_TOP) begin
        hold_d = hold_q + LONG_W'(1);
      end
      long_d = (hold_q == HOLD_PRE);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q  <= ACTIVE_LOW;
      sync2_q  <= ACTIVE_LOW;
      stable_q <= ACTIVE_LOW;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
      hold_q   <= '0;
      long_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      hold_q   <= hold_d;
      long_q   <= long_d;
    end
  end

  always_comb begin
    o_key = pressed_now;
    case (MODE)
      MODE_LEVEL:  o_key = pressed_now;
      MODE_RISE:   o_key = rise_q;
      MODE_FALL:   o_key = fall_q;
      MODE_TOGGLE: o_key = toggle_q;
      default:     o_key = pressed_now;
    endcase
  end

  assign o_level      = pressed_now;
  assign o_long_press = long_q;
  assign o_edge_next  = rise_d | fall_d;

endmodule

// File: rtl/key_input_bank.sv
// Bank of NUM_KEYS independent debounced key channels.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_keys        : raw asynchronous pin levels
//   i_toggle_clr  : per-channel synchronous clear of toggle state
//   o_keys        : per-channel output formed according to MODE
//   o_level       : debounced pressed level, independent of MODE
//   o_long_press  : per-channel one-cycle long-press pulse
//   o_any_event   : one-cycle pulse when any channel has a press/release edge
module key_input_bank
  import key_input_pkg::*;
#(
  parameter int unsigned             NUM_KEYS   = 5,
  parameter int unsigned             CNT_MAX    = 32'h000F_FFFF,
  parameter int unsigned             CNT_W      = 20,
  parameter int unsigned             LONG_MAX   = 100_000_000,
  parameter int unsigned             LONG_W     = 28,
  parameter logic [NUM_KEYS-1:0]     ACTIVE_LOW = '0,
  parameter logic [2*NUM_KEYS-1:0]   MODE       = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_KEYS-1:0] i_keys,
  input  logic [NUM_KEYS-1:0] i_toggle_clr,
  output logic [NUM_KEYS-1:0] o_keys,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_long_press,
  output logic                o_any_event
);

  localparam logic [63:0] MODE_EXT = 64'(MODE);

  logic [NUM_KEYS-1:0] edge_next;
  logic                any_event_q, any_event_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_channel #(
      .CNT_W      (CNT_W),
      .CNT_MAX    (CNT_MAX),
      .LONG_W     (LONG_W),
      .LONG_MAX   (LONG_MAX),
      .ACTIVE_LOW (ACTIVE_LOW[k]),
      .MODE       (get_mode(MODE_EXT, k))
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_key        (i_keys[k]),
      .i_toggle_clr (i_toggle_clr[k]),
      .o_key        (o_keys[k]),
      .o_level      (o_level[k]),
      .o_long_press (o_long_press[k]),
      .o_edge_next  (edge_next[k])
    );
  end

  always_comb begin
    any_event_d = |edge_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      any_event_q <= 1'b0;
    end else begin
      any_event_q <= any_event_d;
    end
  end

  assign o_any_event = any_event_q;

endmodule

// File: tb/tb_key_input_bank.sv
// Self-checking bench for key_input_bank: directed scenarios plus randomized
// key activity, compared every cycle against a behavioural model.
module tb_key_input_bank;
  import key_input_pkg::*;

  localparam int NK = 4;
  localparam int CM = 3;
  localparam int LM = 10;
  localparam logic [7:0] MODES = {MODE_TOGGLE, MODE_FALL, MODE_RISE, MODE_LEVEL};
  localparam logic [3:0] AL    = 4'b1000;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] keys = AL;
  logic [3:0] tclr = 4'b0000;
  logic [3:0] o_keys, o_level, o_long_press;
  logic       o_any_event;

  always #5 clk = ~clk;

  key_input_bank #(
    .NUM_KEYS   (NK),
    .CNT_MAX    (CM),
    .CNT_W      (4),
    .LONG_MAX   (LM),
    .LONG_W     (4),
    .ACTIVE_LOW (AL),
    .MODE       (MODES)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_keys       (keys),
    .i_toggle_clr (tclr),
    .o_keys       (o_keys),
    .o_level      (o_level),
    .o_long_press (o_long_press),
    .o_any_event  (o_any_event)
  );

  int checks = 0;
  int errors = 0;
  int k1cnt  = 0;
  int lcnt   = 0;
  int anycnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin samples pass through a two-deep delay; the debounced value takes the
  // synchronised value once it has disagreed for CM+1 consecutive cycles.
  // Long press fires when the level has been high for exactly LM prior cycles.
  logic [3:0] m_d1, m_d2, m_stable, m_level, m_tog;
  logic [3:0] exp_keys  = '0;
  logic [3:0] exp_level = '0;
  logic [3:0] exp_long  = '0;
  logic       exp_any   = 1'b0;
  int         m_mis[NK];
  int         m_run[NK];

  task automatic model_reset();
    m_d1 = AL; m_d2 = AL; m_stable = AL; m_level = '0; m_tog = '0;
    exp_keys = '0; exp_level = '0; exp_long = '0; exp_any = 1'b0;
    for (int k = 0; k < NK; k++) begin
      m_mis[k] = 0;
      m_run[k] = 0;
    end
  endtask

  task automatic model_step();
    logic any, ol, nl, r, f;
    any = 1'b0;
    for (int k = 0; k < NK; k++) begin
      if (m_d2[k] != m_stable[k]) begin
        m_mis[k]++;
        if (m_mis[k] == CM + 1) begin
          m_stable[k] = m_d2[k];
          m_mis[k]    = 0;
        end
      end else begin
        m_mis[k] = 0;
      end
      m_d2[k] = m_d1[k];
      m_d1[k] = keys[k];
      ol = m_level[k];
      nl = m_stable[k] ^ AL[k];
      r  = nl & ~ol;
      f  = ~nl & ol;
      if (tclr[k]) m_tog[k] = 1'b0;
      else if (r)  m_tog[k] = ~m_tog[k];
      m_run[k]     = ol ? m_run[k] + 1 : 0;
      exp_long[k]  = (m_run[k] == LM);
      m_level[k]   = nl;
      exp_level[k] = nl;
      case (get_mode(64'(MODES), k))
        MODE_LEVEL: exp_keys[k] = nl;
        MODE_RISE:  exp_keys[k] = r;
        MODE_FALL:  exp_keys[k] = f;
        default:    exp_keys[k] = m_tog[k];
      endcase
      any = any | r | f;
    end
    exp_any = any;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- per-cycle compare + pulse monitors ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("o_keys",       32'(o_keys),       32'(exp_keys));
      chk("o_level",      32'(o_level),      32'(exp_level));
      chk("o_long_press", 32'(o_long_press), 32'(exp_long));
      chk("o_any_event",  32'(o_any_event),  32'(exp_any));
      if (o_keys[1])       k1cnt++;
      if (o_long_press[0]) lcnt++;
      if (o_any_event)     anycnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int rl[NK];

  initial begin
    // 1. reset
    rst = 1'b1;
    keys = AL;
    tick(3);
    rst = 1'b0;
    chk("rst_keys",  32'(o_keys),  32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    tick(20);
    chk("idle_any_count", 32'(anycnt), 32'd0);
    chk("idle_level",     32'(o_level), 32'd0);

    // 2. clean press on ch0
    keys[0] = 1'b1;
    tick(5);
    chk("ch0_level_e5", 32'(o_level[0]), 32'd0);
    tick(1);
    chk("ch0_level_e6", 32'(o_level[0]), 32'd1);
    chk("ch0_keys_e6",  32'(o_keys[0]),  32'd1);
    chk("ch0_any_e6",   32'(o_any_event), 32'd1);
    tick(1);
    chk("ch0_any_e7",   32'(o_any_event), 32'd0);
    keys[0] = 1'b0;
    tick(6);
    chk("ch0_rel_level", 32'(o_level[0]),  32'd0);
    chk("ch0_rel_any",   32'(o_any_event), 32'd1);
    tick(4);

    // 3. glitch rejection on ch1 (RISE), fall pulse on ch2 (FALL)
    k1cnt = 0;
    keys[1] = 1'b1;
    tick(3);
    keys[1] = 1'b0;
    tick(12);
    chk("ch1_glitch3", 32'(k1cnt), 32'd0);
    keys[1] = 1'b1;
    tick(4);
    keys[1] = 1'b0;
    tick(12);
    chk("ch1_pulse4", 32'(k1cnt), 32'd1);
    keys[2] = 1'b1;
    tick(10);
    keys[2] = 1'b0;
    tick(5);
    chk("ch2_fall_e5", 32'(o_keys[2]), 32'd0);
    tick(1);
    chk("ch2_fall_e6", 32'(o_keys[2]), 32'd1);
    tick(1);
    chk("ch2_fall_e7", 32'(o_keys[2]), 32'd0);
    tick(4);

    // 4. toggle on active-low ch3
    keys[3] = 1'b0;
    tick(6);
    chk("ch3_tog_1", 32'(o_keys[3]), 32'd1);
    keys[3] = 1'b1;
    tick(10);
    chk("ch3_tog_rel", 32'(o_keys[3]), 32'd1);
    keys[3] = 1'b0;
    tick(6);
    chk("ch3_tog_0", 32'(o_keys[3]), 32'd0);
    keys[3] = 1'b1;
    tick(10);
    keys[3] = 1'b0;
    tick(5);
    tclr[3] = 1'b1;
    tick(1);
    tclr[3] = 1'b0;
    chk("ch3_clr_wins", 32'(o_keys[3]), 32'd0);
    tick(3);
    chk("ch3_clr_hold", 32'(o_keys[3]), 32'd0);
    keys[3] = 1'b1;
    tick(10);

    // 5. long press on ch0
    keys[0] = 1'b1;
    tick(6);
    chk("lp_level", 32'(o_level[0]), 32'd1);
    lcnt = 0;
    tick(9);
    chk("lp_e9",  32'(o_long_press[0]), 32'd0);
    tick(1);
    chk("lp_e10", 32'(o_long_press[0]), 32'd1);
    tick(1);
    chk("lp_e11", 32'(o_long_press[0]), 32'd0);
    tick(13);
    chk("lp_once", 32'(lcnt), 32'd1);
    keys[0] = 1'b0;
    tick(10);
    keys[0] = 1'b1;
    tick(15);
    keys[0] = 1'b0;
    tick(10);
    chk("lp_repress", 32'(lcnt), 32'd2);

    // 6. reset mid-hold
    keys[0] = 1'b1;
    tick(6);
    tick(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_keys",  32'(o_keys),       32'd0);
    chk("arst_level", 32'(o_level),      32'd0);
    chk("arst_long",  32'(o_long_press), 32'd0);
    chk("arst_any",   32'(o_any_event),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    lcnt = 0;
    tick(15);
    chk("arst_no_lp", 32'(lcnt), 32'd0);
    tick(1);
    chk("arst_fresh_lp", 32'(o_long_press[0]), 32'd1);
    keys[0] = 1'b0;
    tick(10);

    // randomized activity
    for (int k = 0; k < NK; k++) rl[k] = int'($urandom_range(1, 20));
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (rl[k] == 0) begin
          keys[k] = ~keys[k];
          rl[k]   = int'($urandom_range(1, 20));
        end else begin
          rl[k]--;
        end
        tclr[k] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        tick(1);
      end
    end
    tclr = '0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
